pipe_skid_stage: RTL and testbench

//   Parametrised pipeline stage register with a valid/ready handshake, an optional
//   2-entry skid buffer, flush, and NOP bubble insertion. Replaces the hand-coded

---
 rtl/pipe_skid_stage.sv | 88 ++++++++
 tb/tb_pipe_skid_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage register with optional 2-entry skid buffer, flush and NOP bubbles
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush_i           drop every held and incoming entry
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload (NOP_VAL when idle)
//   occupancy_o       number of held entries, 0..2
module pipe_skid_stage #(
   parameter int                DATA_W  = 128,
   parameter bit                SKID    = 1'b1,
   parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o
);
   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKIDDED = 2'd2} state_t;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] m_q, m_d, s_q, s_d;
   logic              rdy_q;
   logic              in_fire, out_fire;
   assign out_valid_o = state_q != EMPTY;
   // Registered ready breaks the stall path; without the skid it must be combinational.
   assign in_ready_o  = SKID ? rdy_q : (out_ready_i | ~out_valid_o);
   // M is reloaded with NOP_VAL whenever the stage empties, so it can drive out_data directly.
   assign out_data_o  = m_q;
   assign occupancy_o = state_q;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (flush_i) begin
         state_d = EMPTY;
         m_d     = NOP_VAL;
      end else begin
         case (state_q)
            EMPTY: if (in_fire) begin
               state_d = FULL;
               m_d     = in_data_i;
            end
            FULL: if (in_fire && (out_fire || !SKID)) begin
               m_d = in_data_i;
            end else if (in_fire) begin
               state_d = SKIDDED;
               s_d     = in_data_i;
            end else if (out_fire) begin
               state_d = EMPTY;
               m_d     = NOP_VAL;
            end
            SKIDDED: if (out_fire) begin
               state_d = FULL;
               m_d     = s_q;
            end
            default: begin
               state_d = EMPTY;
               m_d     = NOP_VAL;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         m_q     <= NOP_VAL;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         rdy_q   <= state_d != SKIDDED;
      end
   end
   generate
      if (SKID) begin : g_skid
         always_ff @(posedge clk) s_q <= s_d;
      end else begin : g_noskid
         assign s_q = NOP_VAL;
      end
   endgenerate
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench for pipe_skid_stage with and without the skid buffer
module tb_pipe_skid_stage;
  logic       clk = 1'b0;
  logic       rst, flush;
  logic       iv, ir, ov, ordy;
  logic [7:0] id, od;
  logic [1:0] occ;
  logic       iv0, ir0, ov0, or0;
  logic [7:0] id0, od0;
  logic [1:0] occ0;
  logic [7:0] q[$];
  logic [7:0] q0[$];
  logic [7:0] e;
  int         compared = 0;
  int         mismatched = 0;
  always #5 clk = ~clk;
  pipe_skid_stage #(.DATA_W(8), .SKID(1'b1), .NOP_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(ir), .in_data_i(id),
    .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od), .occupancy_o(occ));
  pipe_skid_stage #(.DATA_W(8), .SKID(1'b0), .NOP_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(id0),
    .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .occupancy_o(occ0));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    #2;
    if (!rst) begin
      if (ov && ordy) begin
        chk("sb_pop", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_data", od, e);
        end
      end else if (!ov) chk("nop", od, 8'h00);
      if (flush) q.delete();
      else if (iv && ir) q.push_back(id);
      if (ov0 && or0) begin
        chk("sb0_pop", q0.size() > 0, 1'b1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("sb0_data", od0, e);
        end
      end
      chk("occ0_le1", occ0 <= 2'd1, 1'b1);
      if (flush) q0.delete();
      else if (iv0 && ir0) q0.push_back(id0);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    mismatched++;
    $error("FAIL timeout: test did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b1; id = 8'hAA; ordy = 1'b0;
    iv0 = 1'b1; id0 = 8'hAA; or0 = 1'b0;
    tick();
    tick();
    rst = 1'b0; iv = 1'b0; iv0 = 1'b0;
    #1;
    chk("rst_ov", ov, 1'b0);
    chk("rst_od", od, 8'h00);
    chk("rst_occ", occ, 2'd0);
    chk("rst_ir", ir, 1'b1);
    chk("rst_ov0", ov0, 1'b0);
    chk("rst_ir0", ir0, 1'b1);
    ordy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iv = 1'b1; id = 8'(i);
      tick();
      chk("stream_ov", ov, 1'b1);
      chk("stream_od", od, 8'(i));
      chk("stream_ir", ir, 1'b1);
    end
    iv = 1'b0;
    tick();
    chk("stream_drain", ov, 1'b0);
    ordy = 1'b0; iv = 1'b1; id = 8'h11;
    tick();
    chk("bp_occ1", occ, 2'd1);
    chk("bp_ir1", ir, 1'b1);
    id = 8'h22;
    tick();
    chk("bp_occ2", occ, 2'd2);
    chk("bp_ir2", ir, 1'b0);
    chk("bp_hold", od, 8'h11);
    id = 8'h99;
    tick();
    chk("bp_stable", od, 8'h11);
    chk("bp_occ_stable", occ, 2'd2);
    iv = 1'b0; ordy = 1'b1;
    tick();
    chk("bp_second", od, 8'h22);
    chk("bp_ir_back", ir, 1'b1);
    chk("bp_occ_back", occ, 2'd1);
    tick();
    chk("bp_empty", ov, 1'b0);
    ordy = 1'b0; iv = 1'b1; id = 8'h11;
    tick();
    id = 8'h22;
    tick();
    id = 8'h33; flush = 1'b1;
    tick();
    flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    chk("fl_ov", ov, 1'b0);
    chk("fl_od", od, 8'h00);
    chk("fl_occ", occ, 2'd0);
    chk("fl_ir", ir, 1'b1);
    tick();
    tick();
    chk("fl_no33", ov, 1'b0);
    ordy = 1'b0; iv = 1'b1; id = 8'h66;
    tick();
    id = 8'h77; flush = 1'b1;
    tick();
    flush = 1'b0; iv = 1'b0; ordy = 1'b1;
    chk("fl2_ov", ov, 1'b0);
    tick();
    chk("fl2_no77", ov, 1'b0);
    ordy = 1'b0; iv = 1'b1; id = 8'h44;
    tick();
    ordy = 1'b1; id = 8'h55;
    tick();
    chk("sim_od", od, 8'h55);
    chk("sim_occ", occ, 2'd1);
    iv = 1'b0;
    tick();
    chk("sim_empty", ov, 1'b0);
    or0 = 1'b0; iv0 = 1'b1; id0 = 8'h66;
    tick();
    iv0 = 1'b0;
    #1;
    chk("s0_ir_low", ir0, 1'b0);
    iv0 = 1'b1; id0 = 8'h77;
    tick();
    chk("s0_hold", od0, 8'h66);
    chk("s0_occ", occ0, 2'd1);
    or0 = 1'b1;
    #1;
    chk("s0_ir_comb", ir0, 1'b1);
    tick();
    chk("s0_next", od0, 8'h77);
    chk("s0_occ2", occ0, 2'd1);
    iv0 = 1'b0;
    tick();
    chk("s0_empty", ov0, 1'b0);
    chk("sb_left", q.size(), 0);
    chk("sb0_left", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
